// File: rtl/add_sub_sequencer.sv
// add_sub_sequencer: control sequencer for a single-bus datapath executing
// ADD / SUB register instructions (fetch T0..T2, execute T3..T5).
//
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-low reset
//   start        begin one fetch/execute cycle (sampled in IDLE only)
//   mem_ready    memory read data valid this cycle
//   ir[31:0]     instruction: [31:27] opcode, [26:23] ra, [22:19] rb, [18:15] rc
//   pc_out .. zlo_out   single-bit datapath strobes
//   op_code[4:0] ALU operation select (non-zero only in T4)
//   r_out, r_in  one-hot GPR bus-drive / write-enable
//   busy         high in every state except IDLE
//   done, fault  one-cycle completion / error pulses
//
// Outputs are a pure decode of the state register and ir, so an asynchronous
// clr drives every output low in the same cycle.
module add_sub_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        mar_in,
  output logic        pc_enable,
  output logic        pc_increment,
  output logic        mdr_read,
  output logic        mdr_enable,
  output logic        mdr_out,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        zlo_enable,
  output logic        zlo_out,
  output logic [4:0]  op_code,
  output logic [15:0] r_out,
  output logic [15:0] r_in,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_N = 16;
  localparam logic [4:0] OPC_ADD = 5'b00011;
  localparam logic [4:0] OPC_SUB = 5'b00100;
  // Last T1 cycle allowed before declaring a memory timeout.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, DONE, FAULT
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       legal;
  logic       unused_ir;

  assign opc       = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign legal     = (opc == OPC_ADD) || (opc == OPC_SUB);
  assign unused_ir = ^ir[14:0];

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= next_state;
  end

  // Memory wait counter: cleared in T0 so it starts at zero on T1 entry.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt <= '0;
    end else if (state == T0) begin
      wait_cnt <= '0;
    end else if (state == T1 && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    next_state   = state;
    pc_out       = 1'b0;
    mar_in       = 1'b0;
    pc_enable    = 1'b0;
    pc_increment = 1'b0;
    mdr_read     = 1'b0;
    mdr_enable   = 1'b0;
    mdr_out      = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    zlo_enable   = 1'b0;
    zlo_out      = 1'b0;
    op_code      = 5'b00000;
    r_out        = '0;
    r_in         = '0;
    busy         = 1'b1;
    done         = 1'b0;
    fault        = 1'b0;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = T0;
      end
      T0: begin
        pc_out       = 1'b1;
        mar_in       = 1'b1;
        pc_enable    = 1'b1;
        pc_increment = 1'b1;
        next_state   = T1;
      end
      T1: begin
        mdr_read   = 1'b1;
        mdr_enable = 1'b1;
        // mem_ready takes priority over a simultaneous timeout.
        if (mem_ready)                  next_state = T2;
        else if (wait_cnt >= WAIT_LAST) next_state = FAULT;
      end
      T2: begin
        mdr_out    = 1'b1;
        ir_enable  = 1'b1;
        next_state = T3;
      end
      T3: begin
        if (legal) begin
          r_out      = REG_N'(1) << rb;
          y_enable   = 1'b1;
          next_state = T4;
        end else begin
          next_state = FAULT;
        end
      end
      T4: begin
        r_out      = REG_N'(1) << rc;
        op_code    = opc;
        zlo_enable = 1'b1;
        next_state = T5;
      end
      T5: begin
        zlo_out    = 1'b1;
        r_in       = REG_N'(1) << ra;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      FAULT: begin
        fault      = 1'b1;
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Testbench for add_sub_sequencer: directed vector table, hand-written reset
// sequences and randomized instructions checked cycle-by-cycle against an
// expected output trace built from the instruction and memory wait length.
module tb_add_sub_sequencer;

  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        pc_out, mar_in, pc_enable, pc_increment, mdr_read, mdr_enable;
  logic        mdr_out, ir_enable, y_enable, zlo_enable, zlo_out;
  logic [4:0]  op_code;
  logic [15:0] r_out, r_in;
  logic        busy, done, fault;

  add_sub_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .mar_in(mar_in), .pc_enable(pc_enable),
    .pc_increment(pc_increment), .mdr_read(mdr_read), .mdr_enable(mdr_enable),
    .mdr_out(mdr_out), .ir_enable(ir_enable), .y_enable(y_enable),
    .zlo_enable(zlo_enable), .zlo_out(zlo_out), .op_code(op_code),
    .r_out(r_out), .r_in(r_in), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_out, mar_in, pc_enable, pc_increment, mdr_read, mdr_enable;
    logic mdr_out, ir_enable, y_enable, zlo_enable, zlo_out;
    logic [4:0]  op_code;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic busy, done, fault;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          w;        // T1 cycles with mem_ready low before it rises
    logic [15:0] r3;       // r_out while y_enable
    logic [15:0] r4;       // r_out while zlo_enable
    logic [15:0] r5;       // r_in while zlo_out
    logic [4:0]  op;       // op_code while zlo_enable
    int          end_cyc;  // 1-based cycle of the done/fault pulse
    logic        is_done;
  } vec_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  obs_t exp_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.pc_out = pc_out; o.mar_in = mar_in; o.pc_enable = pc_enable;
    o.pc_increment = pc_increment; o.mdr_read = mdr_read;
    o.mdr_enable = mdr_enable; o.mdr_out = mdr_out; o.ir_enable = ir_enable;
    o.y_enable = y_enable; o.zlo_enable = zlo_enable; o.zlo_out = zlo_out;
    o.op_code = op_code; o.r_out = r_out; o.r_in = r_in;
    o.busy = busy; o.done = done; o.fault = fault;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected per-cycle outputs from start until the done/fault pulse.
  function automatic void build_trace(input logic [31:0] i, input int w);
    obs_t o;
    logic [4:0] opc = i[31:27];
    bit legal = (opc == 5'd3) || (opc == 5'd4);
    bit to = (w >= int'(TIMEOUT));
    int n_t1 = to ? int'(TIMEOUT) : w + 1;
    exp_q.delete();
    o = '0; o.busy = 1; o.pc_out = 1; o.mar_in = 1; o.pc_enable = 1;
    o.pc_increment = 1; exp_q.push_back(o);
    for (int j = 0; j < n_t1; j++) begin
      o = '0; o.busy = 1; o.mdr_read = 1; o.mdr_enable = 1; exp_q.push_back(o);
    end
    if (to) begin
      o = '0; o.busy = 1; o.fault = 1; exp_q.push_back(o);
      return;
    end
    o = '0; o.busy = 1; o.mdr_out = 1; o.ir_enable = 1; exp_q.push_back(o);
    o = '0; o.busy = 1;
    if (legal) begin
      o.y_enable = 1; o.r_out = 16'd1 << i[22:19];
    end
    exp_q.push_back(o);
    if (!legal) begin
      o = '0; o.busy = 1; o.fault = 1; exp_q.push_back(o);
      return;
    end
    o = '0; o.busy = 1; o.zlo_enable = 1; o.op_code = opc;
    o.r_out = 16'd1 << i[18:15]; exp_q.push_back(o);
    o = '0; o.busy = 1; o.zlo_out = 1; o.r_in = 16'd1 << i[26:23];
    exp_q.push_back(o);
    o = '0; o.busy = 1; o.done = 1; exp_q.push_back(o);
  endfunction

  // Called #1 after an edge while IDLE; leaves the bench #1 after an edge in IDLE.
  task automatic run_model(input string tag, input logic [31:0] i, input int w,
                           input bit poke_start);
    build_trace(i, w);
    ir = i; start = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_obs($sformatf("%s cyc%0d", tag, k + 1), sample(), exp_q[k]);
      mem_ready = (k >= w + 1);
      if (poke_start) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0; mem_ready = 1'b0;
    check_obs($sformatf("%s idle", tag), sample(), obs_t'('0));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    obs_t s;
    logic [15:0] r3 = '0, r4 = '0, r5 = '0;
    logic [4:0]  op = '0;
    int end_cyc = 0;
    bit d = 0, f = 0, ir_seen = 0;
    ir = v.ir; start = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      s = sample();
      if (s.y_enable)   r3 = s.r_out;
      if (s.zlo_enable) begin r4 = s.r_out; op = s.op_code; end
      if (s.zlo_out)    r5 = s.r_in;
      if (s.ir_enable)  ir_seen = 1;
      mem_ready = (cyc >= v.w + 2);
      if (s.done || s.fault) begin
        end_cyc = cyc; d = s.done; f = s.fault;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check_int($sformatf("vec%0d end_cycle", idx), end_cyc, v.end_cyc);
    check_int($sformatf("vec%0d done", idx), int'(d), int'(v.is_done));
    check_int($sformatf("vec%0d fault", idx), int'(f), int'(!v.is_done));
    check_int($sformatf("vec%0d r_out_t3", idx), int'(r3), int'(v.r3));
    check_int($sformatf("vec%0d r_out_t4", idx), int'(r4), int'(v.r4));
    check_int($sformatf("vec%0d op_code_t4", idx), int'(op), int'(v.op));
    check_int($sformatf("vec%0d r_in_t5", idx), int'(r5), int'(v.r5));
    check_int($sformatf("vec%0d ir_enable_seen", idx), int'(ir_seen),
              int'(v.w < int'(TIMEOUT)));
    check_int($sformatf("vec%0d busy_after", idx), int'(busy), 0);
  endtask

  vec_t tbl[10];

  initial begin
    logic [31:0] ri;
    logic [4:0]  ropc;

    // 0x18940000 decodes by field to ra=1 rb=2 rc=8; 0x18918000 is add R1,R2,R3.
    tbl[0] = '{32'h1894_0000,  0, 16'h0004, 16'h0100, 16'h0002, 5'd3,  7, 1'b1};
    tbl[1] = '{32'h1891_8000,  0, 16'h0004, 16'h0008, 16'h0002, 5'd3,  7, 1'b1};
    tbl[2] = '{32'h2000_0000,  0, 16'h0001, 16'h0001, 16'h0001, 5'd4,  7, 1'b1};
    tbl[3] = '{32'h1891_8000,  3, 16'h0004, 16'h0008, 16'h0002, 5'd3, 10, 1'b1};
    tbl[4] = '{32'h1891_8000, 14, 16'h0004, 16'h0008, 16'h0002, 5'd3, 21, 1'b1};
    tbl[5] = '{32'h1891_8000, 15, 16'h0000, 16'h0000, 16'h0000, 5'd0, 17, 1'b0};
    tbl[6] = '{32'h1891_8000, 99, 16'h0000, 16'h0000, 16'h0000, 5'd0, 17, 1'b0};
    tbl[7] = '{32'h5000_0000,  0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  5, 1'b0};
    tbl[8] = '{32'hFFFF_FFFF,  0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  5, 1'b0};
    tbl[9] = '{32'h1FFF_8000,  0, 16'h8000, 16'h8000, 16'h8000, 5'd3,  7, 1'b1};

    clr = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = 32'h1891_8000;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset outputs", sample(), obs_t'('0));
    clr = 1'b1;
    @(posedge clk); #1;
    check_obs("idle no start", sample(), obs_t'('0));

    foreach (tbl[n]) run_vec(n, tbl[n]);

    // Full traces for the directed cases, then start toggled while busy.
    run_model("add_trace", 32'h1891_8000, 0, 1'b0);
    run_model("sub_trace", 32'h2000_0000, 0, 1'b0);
    run_model("wait3_trace", 32'h1891_8000, 3, 1'b0);
    run_model("timeout_trace", 32'h2000_0000, 20, 1'b0);
    run_model("illegal_trace", 32'h5000_0000, 0, 1'b0);
    run_model("busy_start", 32'h1891_8000, 2, 1'b1);

    // Reset in T4: outputs clear at once, then a clean sequence from T0.
    ir = 32'h1891_8000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; mem_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check_int("pre_reset in T4", int'(zlo_enable), 1);
    clr = 1'b0;
    #1;
    check_obs("mid-op reset", sample(), obs_t'('0));
    @(posedge clk); #1;
    check_obs("held reset", sample(), obs_t'('0));
    clr = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    check_obs("no resume", sample(), obs_t'('0));
    run_model("after_reset", 32'h1891_8000, 0, 1'b0);

    // Randomized instructions against the trace model.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       ropc = 5'd3;
        1:       ropc = 5'd4;
        default: ropc = 5'($urandom_range(0, 31));
      endcase
      ri = $urandom;
      ri[31:27] = ropc;
      run_model($sformatf("rand%0d", t), ri, int'($urandom_range(0, 17)),
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
